// File: rtl/accel_top_level.sv
// UART-attached 8x8 multiplier. Receives operand bytes A and B on RxD, returns
// the low byte of A*B on TxD, and mirrors status on the LED bank.
module accel_top_level #(
  parameter int unsigned CLKS_PER_BIT = 87
) (
  input  logic        clk,
  input  logic        sw_reset,
  input  logic        RxD,
  output logic        TxD,
  output logic [15:0] led
);

  localparam int unsigned CntW    = $clog2(CLKS_PER_BIT + 1);
  localparam int unsigned BitLast = CLKS_PER_BIT - 1;
  // Start-bit check lands at the bit centre; two cycles are already spent in the
  // synchronizer and the idle-detect cycle.
  localparam int unsigned RxHalf  = (CLKS_PER_BIT / 2 >= 2) ? CLKS_PER_BIT / 2 - 2 : 0;

  // ---------------------------------------------------------------------------
  // Receiver
  // ---------------------------------------------------------------------------
  typedef enum logic [2:0] {RxIdle, RxStart, RxData, RxStop, RxBreak} rx_state_e;

  rx_state_e       r_rx_state, w_rx_state_next;
  logic            r_rx_sync1, r_rx_sync2;
  logic [CntW-1:0] r_rx_cnt;
  logic [2:0]      r_rx_bit;
  logic [7:0]      r_rx_shift;
  logic [7:0]      r_rx_byte;
  logic            r_rx_done;
  logic            w_rx;
  logic            w_rx_tick_half;
  logic            w_rx_tick_bit;

  assign w_rx           = r_rx_sync2;
  assign w_rx_tick_half = (r_rx_cnt == CntW'(RxHalf));
  assign w_rx_tick_bit  = (r_rx_cnt == CntW'(BitLast));

  // Receiver state register
  always_ff @(posedge clk) begin
    if (!sw_reset) r_rx_state <= RxIdle;
    else           r_rx_state <= w_rx_state_next;
  end

  // Receiver next-state; a framing error parks in RxBreak until the line
  // returns high so a held-low stop bit is not mistaken for a new start bit.
  always_comb begin
    w_rx_state_next = r_rx_state;
    unique case (r_rx_state)
      RxIdle:  if (!w_rx) w_rx_state_next = RxStart;
      RxStart: if (w_rx_tick_half) w_rx_state_next = w_rx ? RxIdle : RxData;
      RxData:  if (w_rx_tick_bit && (r_rx_bit == 3'd7)) w_rx_state_next = RxStop;
      RxStop:  if (w_rx_tick_bit) w_rx_state_next = w_rx ? RxIdle : RxBreak;
      RxBreak: if (w_rx) w_rx_state_next = RxIdle;
      default: w_rx_state_next = RxIdle;
    endcase
  end

  // Receiver synchronizer, bit timing and byte assembly
  always_ff @(posedge clk) begin
    if (!sw_reset) begin
      r_rx_sync1 <= 1'b1;
      r_rx_sync2 <= 1'b1;
      r_rx_cnt   <= '0;
      r_rx_bit   <= '0;
      r_rx_shift <= '0;
      r_rx_byte  <= '0;
      r_rx_done  <= 1'b0;
    end else begin
      r_rx_sync1 <= RxD;
      r_rx_sync2 <= r_rx_sync1;
      r_rx_done  <= 1'b0;
      unique case (r_rx_state)
        RxIdle: begin
          r_rx_cnt <= '0;
          r_rx_bit <= '0;
        end
        RxStart: begin
          if (w_rx_tick_half) r_rx_cnt <= '0;
          else                r_rx_cnt <= r_rx_cnt + CntW'(1);
        end
        RxData: begin
          if (w_rx_tick_bit) begin
            r_rx_cnt   <= '0;
            r_rx_shift <= {w_rx, r_rx_shift[7:1]};
            r_rx_bit   <= r_rx_bit + 3'd1;
          end else begin
            r_rx_cnt <= r_rx_cnt + CntW'(1);
          end
        end
        RxStop: begin
          if (w_rx_tick_bit) begin
            r_rx_cnt <= '0;
            if (w_rx) begin
              r_rx_byte <= r_rx_shift;
              r_rx_done <= 1'b1;
            end
          end else begin
            r_rx_cnt <= r_rx_cnt + CntW'(1);
          end
        end
        RxBreak: r_rx_cnt <= '0;
        default: r_rx_cnt <= '0;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Transmitter
  // ---------------------------------------------------------------------------
  typedef enum logic [1:0] {TxIdle, TxStart, TxData, TxStop} tx_state_e;

  tx_state_e       r_tx_state, w_tx_state_next;
  logic [CntW-1:0] r_tx_cnt;
  logic [2:0]      r_tx_bit;
  logic [7:0]      r_tx_shift;
  logic            r_txd;
  logic            r_tx_done;
  logic            w_tx_tick;
  logic            w_tx_start;
  logic            w_tx_active;
  logic [7:0]      w_tx_data;

  assign w_tx_tick   = (r_tx_cnt == CntW'(BitLast));
  assign w_tx_active = (r_tx_state != TxIdle);

  // Transmitter state register
  always_ff @(posedge clk) begin
    if (!sw_reset) r_tx_state <= TxIdle;
    else           r_tx_state <= w_tx_state_next;
  end

  // Transmitter next-state; a start request while busy is ignored
  always_comb begin
    w_tx_state_next = r_tx_state;
    unique case (r_tx_state)
      TxIdle:  if (w_tx_start) w_tx_state_next = TxStart;
      TxStart: if (w_tx_tick) w_tx_state_next = TxData;
      TxData:  if (w_tx_tick && (r_tx_bit == 3'd7)) w_tx_state_next = TxStop;
      TxStop:  if (w_tx_tick) w_tx_state_next = TxIdle;
      default: w_tx_state_next = TxIdle;
    endcase
  end

  // Transmitter bit timing and serial shifter; TxD is registered
  always_ff @(posedge clk) begin
    if (!sw_reset) begin
      r_tx_cnt   <= '0;
      r_tx_bit   <= '0;
      r_tx_shift <= '0;
      r_txd      <= 1'b1;
      r_tx_done  <= 1'b0;
    end else begin
      r_tx_done <= 1'b0;
      unique case (r_tx_state)
        TxIdle: begin
          r_tx_cnt <= '0;
          r_tx_bit <= '0;
          r_txd    <= 1'b1;
          if (w_tx_start) begin
            r_tx_shift <= w_tx_data;
            r_txd      <= 1'b0;
          end
        end
        TxStart: begin
          if (w_tx_tick) begin
            r_tx_cnt   <= '0;
            r_txd      <= r_tx_shift[0];
            r_tx_shift <= {1'b0, r_tx_shift[7:1]};
          end else begin
            r_tx_cnt <= r_tx_cnt + CntW'(1);
          end
        end
        TxData: begin
          if (w_tx_tick) begin
            r_tx_cnt <= '0;
            r_tx_bit <= r_tx_bit + 3'd1;
            if (r_tx_bit == 3'd7) begin
              r_txd <= 1'b1;
            end else begin
              r_txd      <= r_tx_shift[0];
              r_tx_shift <= {1'b0, r_tx_shift[7:1]};
            end
          end else begin
            r_tx_cnt <= r_tx_cnt + CntW'(1);
          end
        end
        TxStop: begin
          if (w_tx_tick) begin
            r_tx_cnt  <= '0;
            r_tx_done <= 1'b1;
          end else begin
            r_tx_cnt <= r_tx_cnt + CntW'(1);
          end
        end
        default: r_tx_cnt <= '0;
      endcase
    end
  end

  assign TxD = r_txd;

  // ---------------------------------------------------------------------------
  // Control FSM and multiplier
  // ---------------------------------------------------------------------------
  typedef enum logic [1:0] {
    CtlWaitA   = 2'b00,
    CtlWaitB   = 2'b01,
    CtlCompute = 2'b10,
    CtlSend    = 2'b11
  } ctl_state_e;

  ctl_state_e  r_ctl_state, w_ctl_state_next;
  logic [7:0]  r_a, r_b, r_result;
  logic        r_done;
  logic        w_load_a, w_load_b, w_set_done;
  logic [15:0] w_product;

  assign w_product = 16'(r_a) * 16'(r_b);
  // The result is fed straight from the multiplier so the transmitter can
  // latch it in the same cycle the result register loads.
  assign w_tx_data = w_product[7:0];

  // Control state register
  always_ff @(posedge clk) begin
    if (!sw_reset) r_ctl_state <= CtlWaitA;
    else           r_ctl_state <= w_ctl_state_next;
  end

  // Control next-state; bytes arriving in COMPUTE/SEND are dropped
  always_comb begin
    w_ctl_state_next = r_ctl_state;
    unique case (r_ctl_state)
      CtlWaitA:   if (r_rx_done) w_ctl_state_next = CtlWaitB;
      CtlWaitB:   if (r_rx_done) w_ctl_state_next = CtlCompute;
      CtlCompute: w_ctl_state_next = CtlSend;
      CtlSend:    if (r_tx_done) w_ctl_state_next = CtlWaitA;
      default:    w_ctl_state_next = CtlWaitA;
    endcase
  end

  // Control outputs decoded from the current state
  always_comb begin
    w_load_a   = (r_ctl_state == CtlWaitA) && r_rx_done;
    w_load_b   = (r_ctl_state == CtlWaitB) && r_rx_done;
    w_tx_start = (r_ctl_state == CtlCompute);
    w_set_done = (r_ctl_state == CtlSend) && r_tx_done;
  end

  // Operand, result and done-flag registers
  always_ff @(posedge clk) begin
    if (!sw_reset) begin
      r_a      <= '0;
      r_b      <= '0;
      r_result <= '0;
      r_done   <= 1'b0;
    end else begin
      if (w_load_a) begin
        r_a    <= r_rx_byte;
        r_done <= 1'b0;
      end
      if (w_load_b)   r_b      <= r_rx_byte;
      if (w_tx_start) r_result <= w_product[7:0];
      if (w_set_done) r_done   <= 1'b1;
    end
  end

  assign led = {w_tx_active, r_done, r_ctl_state, 4'b0000, r_result};

endmodule

// File: tb/tb_accel_top_level.sv
// Self-checking bench for accel_top_level: drives UART frames on RxD, decodes
// TxD, and compares against an arithmetic model of the multiplier service.
module tb_accel_top_level;

  localparam int unsigned CPB = 16;

  logic        clk = 1'b0;
  logic        sw_reset = 1'b0;
  logic        RxD = 1'b1;
  logic        TxD;
  logic [15:0] led;

  int errors = 0;
  int checks = 0;
  logic [7:0] tx_q[$];

  accel_top_level #(.CLKS_PER_BIT(CPB)) dut (
    .clk      (clk),
    .sw_reset (sw_reset),
    .RxD      (RxD),
    .TxD      (TxD),
    .led      (led)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed no finish, required finish within time limit");
    $fatal(1, "watchdog expired");
  end

  // Host-side UART receiver: decodes each TxD frame at bit centres.
  initial begin
    logic       s_start, s_stop;
    logic [7:0] s_data;
    forever begin
      @(negedge TxD);
      repeat (CPB / 2) @(negedge clk);
      s_start = TxD;
      for (int i = 0; i < 8; i++) begin
        repeat (CPB) @(negedge clk);
        s_data[i] = TxD;
      end
      repeat (CPB) @(negedge clk);
      s_stop = TxD;
      if (!s_start && s_stop) tx_q.push_back(s_data);
    end
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Caller must be at a falling clock edge; consecutive calls give zero gap.
  task automatic send_byte(input logic [7:0] b, input logic stop);
    RxD = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      RxD = b[i];
      repeat (CPB) @(negedge clk);
    end
    RxD = stop;
    repeat (CPB) @(negedge clk);
    RxD = 1'b1;
  endtask

  task automatic wait_result(output logic [7:0] r, output logic ok);
    for (int i = 0; i < 30 * CPB && tx_q.size() == 0; i++) @(negedge clk);
    ok = (tx_q.size() != 0);
    r  = ok ? tx_q.pop_front() : 8'h00;
  endtask

  task automatic run_pair(input logic [7:0] a, input logic [7:0] b, input string tag);
    int         expected;
    logic [7:0] got;
    logic       ok;
    expected = (int'(a) * int'(b)) % 256;
    send_byte(a, 1'b1);
    check({tag, " state after A"}, 16'(led[13:12]), 16'h1);
    check({tag, " done cleared by A"}, 16'(led[14]), 16'h0);
    send_byte(b, 1'b1);
    check({tag, " start bit early"}, {15'h0, TxD}, 16'h0);
    check({tag, " tx busy"}, 16'(led[15]), 16'h1);
    check({tag, " state send"}, 16'(led[13:12]), 16'h3);
    wait_result(got, ok);
    check({tag, " result frame seen"}, 16'(ok), 16'h1);
    check({tag, " TxD byte"}, 16'(got), 16'(expected));
    repeat (CPB) @(negedge clk);
    check({tag, " led result"}, 16'(led[7:0]), 16'(expected));
    check({tag, " done set"}, 16'(led[14]), 16'h1);
    check({tag, " state back to A"}, 16'(led[13:12]), 16'h0);
    check({tag, " tx idle"}, 16'(led[15]), 16'h0);
  endtask

  initial begin
    // Reset
    sw_reset = 1'b0;
    repeat (5) @(negedge clk);
    check("reset TxD", {15'h0, TxD}, 16'h1);
    check("reset led", led, 16'h0000);
    sw_reset = 1'b1;
    repeat (4) @(negedge clk);

    run_pair(8'h05, 8'h07, "p05x07");
    run_pair(8'hC8, 8'h03, "pC8x03");

    // Short low glitch must not start a byte
    RxD = 1'b0;
    repeat (CPB / 2 - 3) @(negedge clk);
    RxD = 1'b1;
    repeat (3 * CPB) @(negedge clk);
    check("glitch state", 16'(led[13:12]), 16'h0);
    check("glitch no tx", 16'(tx_q.size()), 16'h0);

    // Framing error is discarded
    send_byte(8'hA5, 1'b0);
    repeat (2 * CPB) @(negedge clk);
    check("framing state", 16'(led[13:12]), 16'h0);
    run_pair(8'h05, 8'h07, "afterFrame");

    // Reset in the middle of the result frame
    send_byte(8'h09, 1'b1);
    send_byte(8'h0B, 1'b1);
    repeat (3 * CPB) @(negedge clk);
    check("pre-reset tx busy", 16'(led[15]), 16'h1);
    sw_reset = 1'b0;
    @(negedge clk);
    check("midframe reset TxD", {15'h0, TxD}, 16'h1);
    check("midframe reset led", led, 16'h0000);
    @(negedge clk);
    sw_reset = 1'b1;
    repeat (12 * CPB) @(negedge clk);
    tx_q.delete();
    run_pair(8'h02, 8'h04, "afterReset");

    // Back-to-back pairs
    run_pair(8'h05, 8'h07, "b2b1");
    run_pair(8'h03, 8'h03, "b2b2");

    // Random operands
    for (int n = 0; n < 6; n++) begin
      logic [7:0] ra, rb;
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      run_pair(ra, rb, $sformatf("rnd%0d", n));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
